// File: rtl/fft_input_framer_if.sv
// fft_input_framer_if: bus between the ADC sample source / FFT consumer and
// the framer.
//   sample_in, sample_valid : incoming sample stream (no backpressure)
//   frame_ready             : consumer takes the held frame this cycle
//   clear_ovf               : clears the sticky overflow flag
//   out0..out7              : parallel frame, drives FFT in0..in7
//   frame_valid             : out0..out7 hold a complete, untaken frame
//   sample_count            : samples in the current partial frame
//   overflow                : sticky, a completed frame was dropped
// master = source/consumer side, slave = framer side.
interface fft_input_framer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              frame_ready;
  logic              clear_ovf;
  logic [DATA_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic              frame_valid;
  logic [2:0]        sample_count;
  logic              overflow;

  modport master (
    output sample_in, sample_valid, frame_ready, clear_ovf,
    input  out0, out1, out2, out3, out4, out5, out6, out7,
    input  frame_valid, sample_count, overflow
  );

  modport slave (
    input  sample_in, sample_valid, frame_ready, clear_ovf,
    output out0, out1, out2, out3, out4, out5, out6, out7,
    output frame_valid, sample_count, overflow
  );
endinterface

// File: rtl/fft_input_framer.sv
// fft_input_framer: collects 8 offset-corrected ADC samples into a frame and
// presents it in parallel (optionally bit-reversed) under valid/ready.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : fft_input_framer_if.slave (sample stream in, frame out, status)
// Parameters: DATA_W word width, OFFSET subtracted mod 2^DATA_W,
// BIT_REVERSE selects out[k] = frame[bitrev3(k)] instead of frame[k].
module fft_input_framer #(
  parameter int DATA_W      = 16,
  parameter int OFFSET      = 0,
  parameter bit BIT_REVERSE = 1
) (
  input  logic               clk,
  input  logic               rst,
  fft_input_framer_if.slave  bus
);
  localparam logic [DATA_W-1:0] OFF = DATA_W'(OFFSET);

  logic [2:0]                   wr_idx;
  // Only slots 0..6 are stored: the 8th sample goes straight into the frame.
  logic [6:0][DATA_W-1:0]       sbuf;
  logic [7:0][DATA_W-1:0]       out_q;
  logic [7:0][DATA_W-1:0]       frame_w;
  logic [7:0][DATA_W-1:0]       frame_perm;
  logic [DATA_W-1:0]            sample_adj;
  logic                         frame_valid_q;
  logic                         overflow_q;
  logic                         complete;
  logic                         slot_free;
  logic                         load;
  logic                         drop;

  assign sample_adj = bus.sample_in - OFF;
  assign frame_w    = {sample_adj, sbuf};
  assign complete   = bus.sample_valid && (wr_idx == 3'd7);
  assign slot_free  = !frame_valid_q || bus.frame_ready;
  assign load       = complete && slot_free;
  assign drop       = complete && !slot_free;

  // Static output permutation: bitrev3(k) swaps bit 0 and bit 2 of k.
  for (genvar k = 0; k < 8; k++) begin : g_perm
    localparam int SRC = BIT_REVERSE ? (((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)) : k;
    assign frame_perm[k] = frame_w[SRC];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx        <= '0;
      sbuf          <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (bus.sample_valid) begin
        if (wr_idx != 3'd7) sbuf[wr_idx] <= sample_adj;
        wr_idx <= wr_idx + 3'd1;
      end
      // A load while the old frame is being taken keeps frame_valid high.
      if (load) begin
        out_q         <= frame_perm;
        frame_valid_q <= 1'b1;
      end else if (frame_valid_q && bus.frame_ready) begin
        frame_valid_q <= 1'b0;
      end
      // Set has priority over clear.
      if (drop)               overflow_q <= 1'b1;
      else if (bus.clear_ovf) overflow_q <= 1'b0;
    end
  end

  assign bus.out0         = out_q[0];
  assign bus.out1         = out_q[1];
  assign bus.out2         = out_q[2];
  assign bus.out3         = out_q[3];
  assign bus.out4         = out_q[4];
  assign bus.out5         = out_q[5];
  assign bus.out6         = out_q[6];
  assign bus.out7         = out_q[7];
  assign bus.frame_valid  = frame_valid_q;
  assign bus.sample_count = wr_idx;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_fft_input_framer.sv
module tb_fft_input_framer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a: OFFSET=0, BIT_REVERSE=1; dut_b: OFFSET=2048, BIT_REVERSE=0.
  fft_input_framer_if #(.DATA_W(16)) ia ();
  fft_input_framer_if #(.DATA_W(16)) ib ();

  fft_input_framer #(.DATA_W(16), .OFFSET(0), .BIT_REVERSE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia));
  fft_input_framer #(.DATA_W(16), .OFFSET(2048), .BIT_REVERSE(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ib));

  int errors = 0;
  int checks = 0;

  // Reference model: queue of raw samples in the partial frame, held frames.
  logic [15:0]        part[$];
  logic [7:0][15:0]   m_a, m_b;
  bit                 m_fv, m_ovf;
  int                 n_comp = 0;
  int                 n_taken = 0;
  int                 BR[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic logic [7:0][15:0] outs_a();
    return {ia.out7, ia.out6, ia.out5, ia.out4, ia.out3, ia.out2, ia.out1, ia.out0};
  endfunction
  function automatic logic [7:0][15:0] outs_b();
    return {ib.out7, ib.out6, ib.out5, ib.out4, ib.out3, ib.out2, ib.out1, ib.out0};
  endfunction

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit v, input logic [15:0] s, input bit rdy,
                     input bit clr, input bit r);
    logic [15:0] f[8];
    bit comp, dropped;
    ia.sample_valid = v;  ib.sample_valid = v;
    ia.sample_in    = s;  ib.sample_in    = s;
    ia.frame_ready  = rdy; ib.frame_ready = rdy;
    ia.clear_ovf    = clr; ib.clear_ovf   = clr;
    rst = r;
    dropped = 0;
    if (r) begin
      part.delete(); m_a = '0; m_b = '0; m_fv = 0; m_ovf = 0;
    end else begin
      comp = v && (part.size() == 7);
      if (m_fv && rdy) n_taken++;
      if (comp) begin
        for (int k = 0; k < 7; k++) f[k] = part[k];
        f[7] = s;
        part.delete();
        n_comp++;
        if (!m_fv || rdy) begin
          for (int k = 0; k < 8; k++) begin
            m_a[k] = f[BR[k]];
            m_b[k] = f[k] - 16'd2048;
          end
          m_fv = 1;
        end else begin
          m_ovf = 1; dropped = 1;
        end
      end else begin
        if (v) part.push_back(s);
        if (m_fv && rdy) m_fv = 0;
      end
      if (clr && !dropped) m_ovf = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 16'h0, 0, 0, 1);
    cyc(0, 16'h0, 0, 0, 0);
    checks++; if (ia.sample_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ia.sample_count); end
    checks++; if (ia.frame_valid !== 1'b0 || ib.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b/%b exp=0", ia.frame_valid, ib.frame_valid); end
    checks++; if (ia.overflow !== 1'b0 || ib.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b/%b exp=0", ia.overflow, ib.overflow); end
    checks++; if (outs_a() !== '0 || outs_b() !== '0) begin errors++; $display("FAIL reset_outs got=%h/%h exp=0", outs_a(), outs_b()); end
  endtask

  task automatic test_bitrev_frame();
    int smp[8] = '{4095, 4094, 4091, 4093, 4093, 4095, 4093, 4094};
    int w[8]   = '{4095, 4093, 4091, 4093, 4094, 4095, 4093, 4094};
    logic [7:0][15:0] want;
    for (int k = 0; k < 8; k++) want[k] = 16'(w[k]);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'(smp[i]), 1, 0, 0);
      if (i == 6) begin
        checks++; if (ia.frame_valid !== 1'b0) begin errors++; $display("FAIL br_early_fv got=%b exp=0", ia.frame_valid); end
      end
    end
    checks++; if (ia.frame_valid !== 1'b1) begin errors++; $display("FAIL br_fv got=%b exp=1", ia.frame_valid); end
    checks++; if (outs_a() !== want) begin errors++; $display("FAIL br_outs got=%h exp=%h", outs_a(), want); end
    cyc(0, 16'h0, 1, 0, 0);
    checks++; if (ia.frame_valid !== 1'b0) begin errors++; $display("FAIL br_fv_drop got=%b exp=0", ia.frame_valid); end
    checks++; if (outs_a() !== want) begin errors++; $display("FAIL br_hold got=%h exp=%h", outs_a(), want); end
  endtask

  task automatic test_offset();
    int smp[8] = '{4095, 0, 2048, 1, 2047, 4094, 2049, 3072};
    int w[8]   = '{2047, 'hF800, 0, 'hF801, 'hFFFF, 2046, 1, 1024};
    logic [7:0][15:0] want;
    for (int k = 0; k < 8; k++) want[k] = 16'(w[k]);
    for (int i = 0; i < 8; i++) cyc(1, 16'(smp[i]), 1, 0, 0);
    checks++; if (outs_b() !== want) begin errors++; $display("FAIL offset_outs got=%h exp=%h", outs_b(), want); end
    checks++; if (outs_a() !== m_a) begin errors++; $display("FAIL offset_outs_a got=%h exp=%h", outs_a(), m_a); end
    cyc(0, 16'h0, 1, 0, 0);
  endtask

  task automatic test_overflow();
    logic [7:0][15:0] held;
    for (int i = 0; i < 8; i++) cyc(1, 16'($urandom()), 0, 0, 0);
    held = m_a;
    checks++; if (ia.frame_valid !== 1'b1 || outs_a() !== held) begin errors++; $display("FAIL ovf_first fv=%b got=%h exp=%h", ia.frame_valid, outs_a(), held); end
    for (int i = 0; i < 8; i++) cyc(1, 16'($urandom()), 0, 0, 0);
    checks++; if (outs_a() !== held) begin errors++; $display("FAIL ovf_hold got=%h exp=%h", outs_a(), held); end
    checks++; if (ia.overflow !== 1'b1 || ib.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b/%b exp=1", ia.overflow, ib.overflow); end
    checks++; if (ia.sample_count !== 3'd0) begin errors++; $display("FAIL ovf_count got=%0d exp=0", ia.sample_count); end
    cyc(0, 16'h0, 0, 1, 0);
    checks++; if (ia.overflow !== 1'b0 || ia.frame_valid !== 1'b1) begin errors++; $display("FAIL ovf_clear ovf=%b fv=%b exp ovf=0 fv=1", ia.overflow, ia.frame_valid); end
    // Drop and clear in the same cycle: set wins.
    for (int i = 0; i < 7; i++) cyc(1, 16'($urandom()), 0, 0, 0);
    cyc(1, 16'($urandom()), 0, 1, 0);
    checks++; if (ia.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", ia.overflow); end
    cyc(0, 16'h0, 0, 1, 0);
    checks++; if (ia.overflow !== m_ovf) begin errors++; $display("FAIL ovf_clear2 got=%b exp=%b", ia.overflow, m_ovf); end
  endtask

  task automatic test_back_to_back();
    // A frame is still held from the previous test; take it exactly as frame 2 completes.
    for (int i = 0; i < 7; i++) cyc(1, 16'($urandom()), 0, 0, 0);
    cyc(1, 16'($urandom()), 1, 0, 0);
    checks++; if (ia.frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_fv got=%b exp=1", ia.frame_valid); end
    checks++; if (outs_a() !== m_a || outs_b() !== m_b) begin errors++; $display("FAIL b2b_outs got=%h exp=%h", outs_a(), m_a); end
    checks++; if (ia.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", ia.overflow); end
    cyc(0, 16'h0, 1, 0, 0);
  endtask

  task automatic test_reset_midframe();
    logic [7:0][15:0] want;
    int w[8] = '{1, 5, 3, 7, 2, 6, 4, 8};
    for (int k = 0; k < 8; k++) want[k] = 16'(w[k]);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'($urandom()), 0, 0, 0);
      cyc(0, 16'h0, 0, 0, 0);
    end
    checks++; if (ia.sample_count !== 3'd5) begin errors++; $display("FAIL mid_count got=%0d exp=5", ia.sample_count); end
    cyc(0, 16'h0, 0, 0, 1);
    checks++; if (ia.sample_count !== 3'd0 || ia.frame_valid !== 1'b0) begin errors++; $display("FAIL mid_reset count=%0d fv=%b exp 0/0", ia.sample_count, ia.frame_valid); end
    for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 1, 0, 0);
    checks++; if (outs_a() !== want || ia.frame_valid !== 1'b1) begin errors++; $display("FAIL mid_outs got=%h exp=%h", outs_a(), want); end
    cyc(0, 16'h0, 1, 0, 0);
  endtask

  task automatic test_random();
    int start = n_comp;
    int budget = 0;
    while (n_comp < start + 100 && budget < 5000) begin
      cyc(($urandom_range(0, 9) < 7), 16'($urandom()), $urandom_range(0, 1) == 1,
          $urandom_range(0, 19) == 0, 0);
      budget++;
      checks++; if (outs_a() !== m_a || outs_b() !== m_b) begin errors++; $display("FAIL rnd_outs cyc=%0d got=%h exp=%h", budget, outs_a(), m_a); end
      checks++; if (ia.frame_valid !== m_fv || ib.frame_valid !== m_fv) begin errors++; $display("FAIL rnd_fv cyc=%0d got=%b exp=%b", budget, ia.frame_valid, m_fv); end
      checks++; if (ia.overflow !== m_ovf || ib.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", budget, ia.overflow, m_ovf); end
      checks++; if (ia.sample_count !== 3'(part.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", budget, ia.sample_count, part.size()); end
    end
    checks++; if (n_comp < start + 100) begin errors++; $display("FAIL rnd_budget got=%0d exp=%0d frames", n_comp - start, 100); end
  endtask

  initial begin
    rst = 1'b1;
    ia.sample_valid = 0; ia.sample_in = '0; ia.frame_ready = 0; ia.clear_ovf = 0;
    ib.sample_valid = 0; ib.sample_in = '0; ib.frame_ready = 0; ib.clear_ovf = 0;
    test_reset();
    test_bitrev_frame();
    test_offset();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
